// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the SPU instruction fetch stage.
package fetch_unit_pkg;

    // Filler for the empty even slot when fetch lands on an odd address
    localparam logic [0:31] NOP_INSTR   = 32'h4020_0000;
    // Replaces the odd-slot partner of a stop sitting in slot 0
    localparam logic [0:31] LNOP_INSTR  = 32'h0020_0000;
    localparam logic [0:10] STOP_OPCODE = 11'b0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALT
    } fetch_state_t;

    function automatic logic is_stop(input logic [0:31] instr);
        return instr[0:10] == STOP_OPCODE;
    endfunction

endpackage

// File: rtl/fetch_unit_instr_mem.sv
// Instruction memory: two combinational read ports, one synchronous preload port.
// Contents are not touched by reset.
module instr_mem
    import fetch_unit_pkg::*;
#(
    parameter int unsigned PC_W       = 10,
    parameter int unsigned IMEM_DEPTH = 1024
) (
    input  logic            clk,
    input  logic            i_we,
    input  logic [0:PC_W-1] i_waddr,
    input  logic [0:31]     i_wdata,
    input  logic [0:PC_W-1] i_raddr0,
    input  logic [0:PC_W-1] i_raddr1,
    output logic [0:31]     o_rdata0,
    output logic [0:31]     o_rdata1
);

    logic [0:31] r_mem [IMEM_DEPTH];

    // Preload write; reads in the same cycle still see the old word
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata0 = r_mem[i_raddr0];
    assign o_rdata1 = r_mem[i_raddr1];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, IDLE/RUN/HALT control, pair formation and
// branch redirect with a one-cycle flush toward decode/issue.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned PC_W       = 10,
    parameter int unsigned IMEM_DEPTH = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stall,
    input  logic            is_branch,
    input  logic            branch_taken,
    input  logic [0:PC_W-1] new_PC,
    input  logic            preload_IM_en,
    input  logic [0:PC_W-1] preload_IM_addr,
    input  logic [0:31]     preload_IM_data,
    output logic [0:31]     instr0,
    output logic [0:31]     instr1,
    output logic [0:PC_W-1] instr_PC,
    output logic            fetch_valid,
    output logic            flush,
    output logic            halted
);

    fetch_state_t    r_state;
    logic [0:PC_W-1] r_pc;
    logic [0:31]     r_instr0;
    logic [0:31]     r_instr1;
    logic [0:PC_W-1] r_instr_pc;
    logic            r_fetch_valid;
    logic            r_flush;
    logic            r_halted;

    logic [0:31]     w_rd0;
    logic [0:31]     w_rd1;
    logic [0:PC_W-1] w_pc_plus1;
    logic            w_odd;
    logic [0:31]     w_slot0;
    logic [0:31]     w_slot1;
    logic [0:PC_W-1] w_pair_pc;
    logic [0:PC_W-1] w_pc_adv;
    logic            w_stop0;
    logic            w_stop1;
    logic            w_taken;
    logic            w_fetch;
    logic            w_mem_we;

    assign w_pc_plus1 = r_pc + PC_W'(1);
    assign w_odd      = r_pc[PC_W-1];
    assign w_taken    = is_branch && branch_taken;
    assign w_fetch    = !stall && ((r_state == ST_RUN) || (r_state == ST_IDLE && start));
    assign w_mem_we   = preload_IM_en && !rst;

    instr_mem #(
        .PC_W      (PC_W),
        .IMEM_DEPTH(IMEM_DEPTH)
    ) u_imem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (preload_IM_addr),
        .i_wdata (preload_IM_data),
        .i_raddr0(r_pc),
        .i_raddr1(w_pc_plus1),
        .o_rdata0(w_rd0),
        .o_rdata1(w_rd1)
    );

    // Form the issue pair: an odd PC puts its word in slot 1 behind a NOP
    always_comb begin
        w_slot0   = w_odd ? NOP_INSTR : w_rd0;
        w_slot1   = w_odd ? w_rd0 : w_rd1;
        w_pair_pc = r_pc;
        w_pair_pc[PC_W-1] = 1'b0;
        w_pc_adv  = w_odd ? w_pc_plus1 : r_pc + PC_W'(2);
        w_stop0   = is_stop(w_slot0);
        w_stop1   = is_stop(w_slot1);
    end

    // FSM, PC and registered fetch outputs; taken branch beats stall and state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_pc          <= '0;
            r_instr0      <= '0;
            r_instr1      <= '0;
            r_instr_pc    <= '0;
            r_fetch_valid <= 1'b0;
            r_flush       <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_flush <= 1'b0;
            if (w_taken) begin
                r_pc          <= new_PC;
                r_fetch_valid <= 1'b0;
                r_flush       <= 1'b1;
                if (r_state == ST_HALT) begin
                    r_state  <= ST_RUN;
                    r_halted <= 1'b0;
                end
            end else begin
                case (r_state)
                    ST_IDLE: if (start) r_state <= ST_RUN;
                    ST_HALT: if (!stall) r_fetch_valid <= 1'b0;
                    default: ;
                endcase
                // The stop pair itself still issues; HALT takes over next cycle
                if (w_fetch) begin
                    r_instr0      <= w_slot0;
                    r_instr1      <= w_stop0 ? LNOP_INSTR : w_slot1;
                    r_instr_pc    <= w_pair_pc;
                    r_pc          <= w_pc_adv;
                    r_fetch_valid <= 1'b1;
                    if (w_stop0 || w_stop1) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end
                end
            end
        end
    end

    assign instr0      = r_instr0;
    assign instr1      = r_instr1;
    assign instr_PC    = r_instr_pc;
    assign fetch_valid = r_fetch_valid;
    assign flush       = r_flush;
    assign halted      = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed walk through the fetch scenarios followed by
// randomized traffic, all checked against a cycle-level reference model.
module tb_fetch_unit;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;
    localparam logic [31:0] NOP  = 32'h4020_0000;
    localparam logic [31:0] LNOP = 32'h0020_0000;
    localparam logic [31:0] STOPW = 32'h0000_0123;

    logic        clk = 1'b0;
    logic        rst, start, stall, is_branch, branch_taken;
    logic [9:0]  new_PC;
    logic        preload_IM_en;
    logic [9:0]  preload_IM_addr;
    logic [31:0] preload_IM_data;
    logic [31:0] instr0, instr1;
    logic [9:0]  instr_PC;
    logic        fetch_valid, flush, halted;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [31:0] m_mem [1024];
    logic [31:0] img   [1024];
    int          m_pc, m_st, m_ipc;
    logic [31:0] m_i0, m_i1;
    logic        m_valid, m_flush, m_halted;

    fetch_unit #(.PC_W(10), .IMEM_DEPTH(1024)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .stall          (stall),
        .is_branch      (is_branch),
        .branch_taken   (branch_taken),
        .new_PC         (new_PC),
        .preload_IM_en  (preload_IM_en),
        .preload_IM_addr(preload_IM_addr),
        .preload_IM_data(preload_IM_data),
        .instr0         (instr0),
        .instr1         (instr1),
        .instr_PC       (instr_PC),
        .fetch_valid    (fetch_valid),
        .flush          (flush),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w[31:21] == 11'd0) w[31] = 1'b1;
        return w;
    endfunction

    function automatic logic is_stop_w(input logic [31:0] w);
        return w[31:21] == 11'd0;
    endfunction

    // One clock of the behavioural model, from the inputs seen at this edge
    task automatic model_step();
        if (rst) begin
            m_pc = 0; m_st = M_IDLE; m_i0 = '0; m_i1 = '0; m_ipc = 0;
            m_valid = 1'b0; m_flush = 1'b0; m_halted = 1'b0;
        end else begin
            m_flush = 1'b0;
            if (is_branch && branch_taken) begin
                m_pc = int'(new_PC);
                m_valid = 1'b0;
                m_flush = 1'b1;
                if (m_st == M_HALT) begin
                    m_st = M_RUN;
                    m_halted = 1'b0;
                end
            end else begin
                if (m_st == M_IDLE && start) m_st = M_RUN;
                else if (m_st == M_HALT && !stall) m_valid = 1'b0;
                if (m_st == M_RUN && !stall) begin
                    if (m_pc % 2 == 0) begin
                        m_i0 = m_mem[m_pc];
                        m_i1 = m_mem[(m_pc + 1) % 1024];
                        m_ipc = m_pc;
                        m_pc = (m_pc + 2) % 1024;
                    end else begin
                        m_i0 = NOP;
                        m_i1 = m_mem[m_pc];
                        m_ipc = m_pc - 1;
                        m_pc = (m_pc + 1) % 1024;
                    end
                    m_valid = 1'b1;
                    if (is_stop_w(m_i0)) begin
                        m_i1 = LNOP;
                        m_st = M_HALT;
                        m_halted = 1'b1;
                    end else if (is_stop_w(m_i1)) begin
                        m_st = M_HALT;
                        m_halted = 1'b1;
                    end
                end
            end
            if (preload_IM_en) m_mem[preload_IM_addr] = preload_IM_data;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("instr0", instr0, m_i0);
        check("instr1", instr1, m_i1);
        check("instr_PC", 32'(instr_PC), 32'(m_ipc));
        check("fetch_valid", 32'(fetch_valid), 32'(m_valid));
        check("flush", 32'(flush), 32'(m_flush));
        check("halted", 32'(halted), 32'(m_halted));
    endtask

    task automatic branch_to(input int tgt);
        is_branch = 1'b1; branch_taken = 1'b1; new_PC = 10'(tgt);
        tick();
        is_branch = 1'b0; branch_taken = 1'b0;
    endtask

    initial begin
        logic [31:0] xw;
        rst = 1'b1; start = 1'b0; stall = 1'b0; is_branch = 1'b0; branch_taken = 1'b0;
        new_PC = '0; preload_IM_en = 1'b0; preload_IM_addr = '0; preload_IM_data = '0;
        m_pc = 0; m_st = M_IDLE; m_ipc = 0; m_i0 = '0; m_i1 = '0;
        m_valid = 1'b0; m_flush = 1'b0; m_halted = 1'b0;

        tick(); tick();
        check("rst_valid", 32'(fetch_valid), 32'd0);
        check("rst_instr0", instr0, 32'd0);
        rst = 1'b0;

        // preload the whole memory: A..D at 0..3, stop at 12
        for (int a = 0; a < 1024; a++) img[a] = rand_word();
        img[0] = 32'hA000_0001; img[1] = 32'hB000_0002;
        img[2] = 32'hC000_0003; img[3] = 32'hD000_0004;
        img[12] = STOPW;
        preload_IM_en = 1'b1;
        for (int a = 0; a < 1024; a++) begin
            preload_IM_addr = 10'(a);
            preload_IM_data = img[a];
            tick();
        end
        preload_IM_en = 1'b0;
        tick();
        check("idle_no_valid", 32'(fetch_valid), 32'd0);

        // start: (A,B,0) then (C,D,2)
        start = 1'b1; tick(); start = 1'b0;
        check("start_i0", instr0, img[0]);
        check("start_i1", instr1, img[1]);
        check("start_valid", 32'(fetch_valid), 32'd1);
        tick();
        check("pair2_i0", instr0, img[2]);
        check("pair2_pc", 32'(instr_PC), 32'd2);
        tick();
        check("pair4_pc", 32'(instr_PC), 32'd4);

        // taken branch to 9
        branch_to(9);
        check("br_flush", 32'(flush), 32'd1);
        check("br_valid", 32'(fetch_valid), 32'd0);
        tick();
        check("odd_i0", instr0, NOP);
        check("odd_i1", instr1, img[9]);
        check("odd_pc", 32'(instr_PC), 32'd8);
        check("odd_flush_gone", 32'(flush), 32'd0);
        tick();
        check("after_odd_i0", instr0, img[10]);
        check("after_odd_pc", 32'(instr_PC), 32'd10);

        // stall 3 cycles, then resume with the next pair
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", 32'(instr_PC), 32'd10);
            check("stall_i1", instr1, img[11]);
        end
        stall = 1'b0;
        tick();
        check("stop_i0", instr0, STOPW);
        check("stop_i1", instr1, LNOP);
        check("stop_pc", 32'(instr_PC), 32'd12);
        check("stop_valid", 32'(fetch_valid), 32'd1);
        check("stop_halted", 32'(halted), 32'd1);
        tick(); tick();
        check("halt_valid", 32'(fetch_valid), 32'd0);
        check("halt_halted", 32'(halted), 32'd1);

        // exit HALT via taken branch to 20
        branch_to(20);
        check("exit_halted", 32'(halted), 32'd0);
        tick();
        check("exit_i0", instr0, img[20]);
        check("exit_i1", instr1, img[21]);
        check("exit_valid", 32'(fetch_valid), 32'd1);

        // wrap at 1022, then odd target 1023
        branch_to(1022);
        tick();
        check("wrap_i1", instr1, img[1023]);
        check("wrap_pc", 32'(instr_PC), 32'd1022);
        tick();
        check("wrap0_i0", instr0, img[0]);
        check("wrap0_pc", 32'(instr_PC), 32'd0);
        branch_to(1023);
        tick();
        check("odd_wrap_i0", instr0, NOP);
        check("odd_wrap_i1", instr1, img[1023]);
        check("odd_wrap_pc", 32'(instr_PC), 32'd1022);
        tick();
        check("odd_wrap_next", 32'(instr_PC), 32'd0);

        // preload addr 2 while PC 2 is fetched: old word issued
        xw = 32'h7777_5555;
        preload_IM_en = 1'b1; preload_IM_addr = 10'd2; preload_IM_data = xw;
        tick();
        preload_IM_en = 1'b0;
        check("rbw_i0", instr0, img[2]);

        // reset together with a taken branch
        rst = 1'b1; is_branch = 1'b1; branch_taken = 1'b1; new_PC = 10'd5;
        tick();
        rst = 1'b0; is_branch = 1'b0; branch_taken = 1'b0;
        check("rst_br_flush", 32'(flush), 32'd0);
        check("rst_br_pc", 32'(instr_PC), 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        check("restart_i0", instr0, img[0]);
        tick();
        check("new_word_i0", instr0, xw);

        // randomized traffic
        for (int c = 0; c < 800; c++) begin
            rst          = ($urandom_range(0, 99) == 0);
            start        = ($urandom_range(0, 7) == 0);
            stall        = ($urandom_range(0, 3) == 0);
            is_branch    = ($urandom_range(0, 9) == 0);
            branch_taken = $urandom_range(0, 1) == 1;
            new_PC       = 10'($urandom);
            preload_IM_en   = ($urandom_range(0, 5) == 0);
            preload_IM_addr = 10'($urandom);
            preload_IM_data = ($urandom_range(0, 7) == 0) ? STOPW : rand_word();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
